// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx
// Brief    : I2S receiver; oversamples sck/lrck/sdin on clk, emits L/R pairs
//            on a single-stage valid/ready port with an overrun pulse.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck,
    input  logic             lrck,
    input  logic             sdin,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right,
    output logic             valid,
    input  logic             ready,
    output logic             overrun
);

    localparam int                c_cntw = $clog2(WIDTH + 1);
    localparam logic [c_cntw-1:0] c_full = c_cntw'(WIDTH);
    localparam logic [c_cntw-1:0] c_one  = c_cntw'(1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_sck_s1, r_sck_s2, r_sck_h;
    logic              r_lr_s1, r_lr_s2, r_lr_prev;
    logic              r_sd_s1, r_sd_s2;
    logic [c_cntw-1:0] r_cnt;
    logic [c_cntw-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]  r_shift;
    logic [WIDTH-1:0]  w_shift_nxt;
    logic [WIDTH-1:0]  w_word;
    logic [WIDTH-1:0]  r_hold_l;
    logic [WIDTH-1:0]  r_hold_r;
    logic              r_pend;
    logic              w_rise;
    logic              w_lr_up;
    logic              w_lr_dn;
    logic              w_close_l;
    logic              w_close_r;

    // Equal depth on all three inputs keeps lrck/sdin aligned with the sck edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_s1 <= 1'b0;
            r_sck_s2 <= 1'b0;
            r_sck_h  <= 1'b0;
            r_lr_s1  <= 1'b0;
            r_lr_s2  <= 1'b0;
            r_sd_s1  <= 1'b0;
            r_sd_s2  <= 1'b0;
        end else begin
            r_sck_s1 <= sck;
            r_sck_s2 <= r_sck_s1;
            r_sck_h  <= r_sck_s2;
            r_lr_s1  <= lrck;
            r_lr_s2  <= r_lr_s1;
            r_sd_s1  <= sdin;
            r_sd_s2  <= r_sd_s1;
        end
    end

    assign w_rise  = r_sck_s2 & ~r_sck_h;
    assign w_lr_up = w_rise & r_lr_s2 & ~r_lr_prev;
    assign w_lr_dn = w_rise & ~r_lr_s2 & r_lr_prev;

    // The bit on a closing edge is the old channel's LSB, so the closed word
    // includes it; short words are left-justified.
    always_comb begin
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        if (r_cnt < c_full) begin
            w_shift_nxt = {r_shift[WIDTH-2:0], r_sd_s2};
            w_cnt_nxt   = r_cnt + c_one;
        end
        w_word = w_shift_nxt << (c_full - w_cnt_nxt);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_close_l   = 1'b0;
        w_close_r   = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_lr_dn) w_state_nxt = LEFT;
            end
            LEFT: begin
                if (w_lr_up) begin
                    w_close_l   = 1'b1;
                    w_state_nxt = RIGHT;
                end
            end
            RIGHT: begin
                if (w_lr_dn) begin
                    w_close_r   = 1'b1;
                    w_state_nxt = LEFT;
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= HUNT;
            r_lr_prev <= 1'b0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_hold_l  <= '0;
            r_hold_r  <= '0;
            r_pend    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_close_r;
            if (w_rise) begin
                r_lr_prev <= r_lr_s2;
                if (w_lr_up || w_lr_dn) begin
                    r_cnt   <= '0;
                    r_shift <= '0;
                end else begin
                    r_cnt   <= w_cnt_nxt;
                    r_shift <= w_shift_nxt;
                end
            end
            if (w_close_l) r_hold_l <= w_word;
            if (w_close_r) r_hold_r <= w_word;
        end
    end

    // Single output stage: a new pair only loads if the old one is gone or
    // being taken this cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left    <= '0;
            right   <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (r_pend) begin
                if (!valid || ready) begin
                    left  <= r_hold_l;
                    right <= r_hold_r;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_rx
// Brief    : Scoreboard bench for i2s_rx; frame-level I2S model drives the
//            expected-pair queue, a monitor compares each accepted pair.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2s_rx;

    localparam int W = 16;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         sck   = 1'b0;
    logic         lrck  = 1'b0;
    logic         sdin  = 1'b0;
    logic         ready = 1'b1;
    logic [W-1:0] left;
    logic [W-1:0] right;
    logic         valid;
    logic         overrun;

    i2s_rx #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .sck     (sck),
        .lrck    (lrck),
        .sdin    (sdin),
        .left    (left),
        .right   (right),
        .valid   (valid),
        .ready   (ready),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } pair_t;

    pair_t q[$];
    int    total    = 0;
    int    bad      = 0;
    int    ovr_seen = 0;
    int    ovr_exp  = 0;

    // Reference model state: lrck history, bits of the current slot,
    // whether a falling lrck has been seen since reset, pending left word.
    bit              m_prev;
    bit              m_seen_fall;
    bit              m_left_done;
    bit              m_occ;
    longint unsigned m_acc;
    int              m_n;
    logic [W-1:0]    m_left;

    function automatic logic [W-1:0] just(longint unsigned acc, int n);
        longint unsigned v;
        if (n >= W) v = acc >> (n - W);
        else        v = acc << (W - n);
        return v[W-1:0];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_prev      = 1'b0;
        m_seen_fall = 1'b0;
        m_left_done = 1'b0;
        m_occ       = 1'b0;
        m_acc       = 0;
        m_n         = 0;
        q.delete();
    endtask

    task automatic set_ready(logic v);
        @(negedge clk);
        ready = v;
        if (v) m_occ = 1'b0;
    endtask

    task automatic send_bit(logic lr, logic sd, int half);
        pair_t p;
        bit    emit;
        bit    lat;
        emit = 1'b0;
        lat  = 1'b0;
        p    = '0;
        @(negedge clk);
        sck  = 1'b0;
        lrck = lr;
        sdin = sd;
        m_acc = (m_acc << 1) | longint'(sd);
        m_n++;
        if (lr != m_prev) begin
            if (lr && m_seen_fall) begin
                m_left      = just(m_acc, m_n);
                m_left_done = 1'b1;
            end else if (!lr) begin
                if (m_seen_fall && m_left_done) begin
                    p.l  = m_left;
                    p.r  = just(m_acc, m_n);
                    emit = 1'b1;
                end
                m_seen_fall = 1'b1;
                m_left_done = 1'b0;
            end
            m_acc = 0;
            m_n   = 0;
        end
        m_prev = lr;
        if (emit) begin
            if (ready) begin
                q.push_back(p);
                lat = (half >= 4);
            end else if (!m_occ) begin
                q.push_back(p);
                m_occ = 1'b1;
            end else begin
                ovr_exp++;
            end
        end
        repeat (half) @(negedge clk);
        sck = 1'b1;
        if (lat) begin
            repeat (3) @(negedge clk);
            chk("latency_not_yet", {31'd0, valid}, 32'd0);
            @(negedge clk);
            chk("latency_valid", {31'd0, valid}, 32'd1);
            repeat (half - 4) @(negedge clk);
        end else begin
            repeat (half) @(negedge clk);
        end
    endtask

    task automatic send_slot(logic [31:0] val, int nbits, logic ch, int half);
        for (int k = 0; k < nbits; k++)
            send_bit((k == nbits - 1) ? ~ch : ch, val[nbits-1-k], half);
    endtask

    task automatic send_frame(logic [31:0] lv, int ln, logic [31:0] rv, int rn, int half);
        send_slot(lv, ln, 1'b0, half);
        send_slot(rv, rn, 1'b1, half);
    endtask

    // Monitor: pops one expected pair per handshake; counts overrun pulses.
    always @(negedge clk) begin
        pair_t e;
        #1;
        if (overrun) ovr_seen++;
        if (!rst && valid && ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pair: got %0h/%0h expected none", left, right);
            end else begin
                e = q.pop_front();
                chk("pair_left", {16'd0, left}, {16'd0, e.l});
                chk("pair_right", {16'd0, right}, {16'd0, e.r});
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        chk("reset_left", {16'd0, left}, 32'd0);
        chk("reset_right", {16'd0, right}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Right slot ending in a falling lrck arms the receiver.
        send_slot(32'h0, 16, 1'b1, 4);

        repeat (3) send_frame(32'h12340000, 32, 32'hABCD0000, 32, 16);
        send_frame(32'h00A5A5A5, 24, 32'h000000FF, 8, 4);

        for (int i = 0; i < 5; i++)
            send_frame($urandom, $urandom_range(8, 32), $urandom, $urandom_range(8, 32),
                       $urandom_range(3, 6));

        // Backpressure: first pair held, the next two dropped.
        set_ready(1'b0);
        send_frame(32'd1, 16, 32'd2, 16, 4);
        send_frame(32'd3, 16, 32'd4, 16, 4);
        send_frame(32'd5, 16, 32'd6, 16, 4);
        repeat (5) @(negedge clk);
        chk("bp_hold_left", {16'd0, left}, 32'd1);
        chk("bp_hold_right", {16'd0, right}, 32'd2);
        chk("bp_hold_valid", {31'd0, valid}, 32'd1);
        chk("bp_overruns", ovr_seen, ovr_exp);
        set_ready(1'b1);
        repeat (2) @(negedge clk);
        chk("bp_drained_valid", {31'd0, valid}, 32'd0);

        // Reset released partway through a right slot.
        @(negedge clk);
        rst = 1'b1;
        sck = 1'b0;
        lrck = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) send_bit(1'b1, 1'($urandom), 4);
        send_bit(1'b0, 1'($urandom), 4);
        repeat (2) send_frame($urandom, 16, $urandom, 16, 4);

        // Reset mid-left-slot while a pair is held.
        set_ready(1'b0);
        send_frame(32'h0000BEEF, 16, 32'h0000CAFE, 16, 4);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'($urandom), 4);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_left", {16'd0, left}, 32'd0);
        chk("async_rst_right", {16'd0, right}, 32'd0);
        chk("async_rst_valid", {31'd0, valid}, 32'd0);
        sck = 1'b0;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        set_ready(1'b1);
        for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom), 4);
        send_bit(1'b1, 1'($urandom), 4);
        send_slot($urandom, 16, 1'b1, 4);
        repeat (2) send_frame($urandom, 16, $urandom, 16, 4);

        // Loopback-style stream at minimum sck phase length.
        repeat (4) send_frame($urandom, 32, $urandom, 32, 3);

        repeat (20) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        chk("overrun_total", ovr_seen, ovr_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
